// File: rtl/loot_pkg.sv
// loot_pkg: shared types and constants for the loot manager slice.
// Holds slot states, item geometry, lane table, play area and LFSR seed.
package loot_pkg;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_ACTIVE  = 2'd1,
    S_OFFERED = 2'd2
  } slot_state_e;

  localparam int         ITEM_SIZE  = 16;
  localparam logic [9:0] AREA_X_MIN = 10'd100;
  localparam logic [9:0] AREA_X_MAX = 10'd739;
  localparam logic [9:0] AREA_Y_MIN = 10'd65;
  localparam logic [9:0] AREA_Y_MAX = 10'd448;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [9:0] lane_y(
    input logic [1:0] idx
  );
    logic [9:0] y;
    unique case (idx)
      2'd0:    y = 10'd96;
      2'd1:    y = 10'd192;
      2'd2:    y = 10'd288;
      default: y = 10'd384;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/loot_manager_if.sv
// loot_manager_if: player, raster and offer signals of the loot manager.
// master = player/raster side, slave = loot_manager.
interface loot_manager_if;
  logic       RoundEnable;
  logic [9:0] P1X, P1Y, P2X, P2Y;
  logic [4:0] P1HbOffset, P2HbOffset;
  logic       P1Dead, P2Dead;
  logic       P1Collected, P2Collected;
  logic [9:0] DrawX, DrawY;
  logic [1:0] P1Collect, P2Collect;
  logic       LootPixel;
  logic [1:0] LootValue;

  modport master (
    output RoundEnable,
    output P1X, P1Y, P2X, P2Y,
    output P1HbOffset, P2HbOffset,
    output P1Dead, P2Dead,
    output P1Collected, P2Collected,
    output DrawX, DrawY,
    input  P1Collect, P2Collect,
    input  LootPixel, LootValue
  );

  modport slave (
    input  RoundEnable,
    input  P1X, P1Y, P2X, P2Y,
    input  P1HbOffset, P2HbOffset,
    input  P1Dead, P2Dead,
    input  P1Collected, P2Collected,
    input  DrawX, DrawY,
    output P1Collect, P2Collect,
    output LootPixel, LootValue
  );
endinterface

// File: rtl/collision.sv
// collision: strict overlap test of two WxH boxes, 10-bit unsigned.
// Edges that only touch do not count as overlap.
module collision
  import loot_pkg::*;
#(
  parameter int W = ITEM_SIZE,
  parameter int H = ITEM_SIZE
) (
  input  logic [9:0] i_ax,
  input  logic [9:0] i_ay,
  input  logic [9:0] i_bx,
  input  logic [9:0] i_by,
  output logic       o_hit
);

  logic [9:0] w_axe, w_aye, w_bxe, w_bye;

  assign w_axe = i_ax + 10'(W);
  assign w_aye = i_ay + 10'(H);
  assign w_bxe = i_bx + 10'(W);
  assign w_bye = i_by + 10'(H);

  assign o_hit = (i_ax < w_bxe) && (i_bx < w_axe)
              && (i_ay < w_bye) && (i_by < w_aye);

endmodule

// File: rtl/loot_slot.sv
// loot_slot: one item slot (EMPTY/ACTIVE/OFFERED) with respawn counter.
// Reports raw player overlaps and raster hits; arbitration lives above.
module loot_slot
  import loot_pkg::*;
#(
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_grant,
  input  logic        i_owner,
  input  logic        i_coll1,
  input  logic        i_coll2,
  input  logic [9:0]  i_spawn_x,
  input  logic [9:0]  i_spawn_y,
  input  logic [1:0]  i_spawn_v,
  input  logic [9:0]  i_h1x,
  input  logic [9:0]  i_h1y,
  input  logic [9:0]  i_h2x,
  input  logic [9:0]  i_h2y,
  input  logic [9:0]  i_draw_x,
  input  logic [9:0]  i_draw_y,
  output slot_state_e o_state,
  output logic [1:0]  o_value,
  output logic        o_hit1,
  output logic        o_hit2,
  output logic        o_pix
);

  localparam logic [7:0] CNT_INIT = 8'(RESPAWN_FRAMES - 1);

  slot_state_e r_state, w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_owner;
  logic [1:0]  r_value;
  logic [9:0]  r_x, r_y;
  logic [9:0]  w_xe, w_ye;
  logic        w_coll;

  assign w_coll = r_owner ? i_coll2 : i_coll1;
  assign w_xe   = r_x + 10'(ITEM_SIZE);
  assign w_ye   = r_y + 10'(ITEM_SIZE);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= S_EMPTY;
      r_cnt   <= CNT_INIT;
      r_owner <= 1'b0;
      r_value <= 2'd0;
      r_x     <= 10'd0;
      r_y     <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_EMPTY) begin
        if (r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
        end else begin
          r_x     <= i_spawn_x;
          r_y     <= i_spawn_y;
          r_value <= i_spawn_v;
        end
      end
      if (r_state == S_ACTIVE && i_grant) r_owner <= i_owner;
      // Reload here so the slot is empty for the full respawn time.
      if (r_state == S_OFFERED && w_coll) r_cnt <= CNT_INIT;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY:   if (r_cnt == 8'd0) w_state_nxt = S_ACTIVE;
      S_ACTIVE:  if (i_grant) w_state_nxt = S_OFFERED;
      S_OFFERED: w_state_nxt = w_coll ? S_EMPTY : S_ACTIVE;
      default:   w_state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    o_state = r_state;
    o_value = r_value;
    o_pix   = (r_state != S_EMPTY)
           && (i_draw_x >= r_x) && (i_draw_x < w_xe)
           && (i_draw_y >= r_y) && (i_draw_y < w_ye);
  end

  collision u_hit1 (
    .i_ax  (i_h1x),
    .i_ay  (i_h1y),
    .i_bx  (r_x),
    .i_by  (r_y),
    .o_hit (o_hit1)
  );

  collision u_hit2 (
    .i_ax  (i_h2x),
    .i_ay  (i_h2y),
    .i_bx  (r_x),
    .i_by  (r_y),
    .o_hit (o_hit2)
  );

endmodule

// File: rtl/loot_manager.sv
// loot_manager: spawns loot, arbitrates player grabs, drives loot pixels.
// Define LOOT_RANDOM_EN for LFSR-driven spawn position and value.
module loot_manager
  import loot_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int RESPAWN_FRAMES = 120
) (
  input logic           FrameClk,
  input logic           Reset,
  loot_manager_if.slave bus
);

  logic       w_clr;
  logic [9:0] w_h1x, w_h1y, w_h2x, w_h2y;

  assign w_clr = Reset | ~bus.RoundEnable;
  assign w_h1x = bus.P1X + {5'd0, bus.P1HbOffset};
  assign w_h1y = bus.P1Y + 10'(ITEM_SIZE);
  assign w_h2x = bus.P2X + {5'd0, bus.P2HbOffset};
  assign w_h2y = bus.P2Y + 10'(ITEM_SIZE);

  slot_state_e          w_st  [NUM_SLOTS];
  logic [1:0]           w_val [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_hit1, w_hit2, w_pix;
  logic [NUM_SLOTS-1:0] w_ov1, w_ov2, w_grant, w_owner;

  logic       r_busy1, r_busy2, r_rr;
  logic [1:0] r_p1c, r_p2c;
  logic [1:0] w_c1, w_c2;
  logic       w_c1_vld, w_c2_vld;
  logic       w_e1, w_e2, w_contest, w_g1, w_g2;

`ifdef LOOT_RANDOM_EN
  logic [15:0] r_lfsr;
  logic [9:0]  w_rnd_x, w_rnd_y;
  logic [1:0]  w_rnd_v;

  always_ff @(posedge FrameClk) begin
    if (w_clr) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[14:0],
                          r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // 9-bit field never reaches 608, so the modulo is the identity.
  assign w_rnd_x = AREA_X_MIN + {1'b0, r_lfsr[8:0]};
  assign w_rnd_y = lane_y(r_lfsr[10:9]);
  assign w_rnd_v = (r_lfsr[12:11] == 2'd0) ? 2'd1 : r_lfsr[12:11];
`endif

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic [9:0] w_sx, w_sy;
    logic [1:0] w_sv;
`ifdef LOOT_RANDOM_EN
    assign w_sx = w_rnd_x;
    assign w_sy = w_rnd_y;
    assign w_sv = w_rnd_v;
`else
    assign w_sx = 10'(160 + 128 * g);
    assign w_sy = lane_y(2'(g));
    assign w_sv = 2'((g % 3) + 1);
`endif

    loot_slot #(
      .RESPAWN_FRAMES (RESPAWN_FRAMES)
    ) u_slot (
      .i_clk     (FrameClk),
      .i_clr     (w_clr),
      .i_grant   (w_grant[g]),
      .i_owner   (w_owner[g]),
      .i_coll1   (bus.P1Collected),
      .i_coll2   (bus.P2Collected),
      .i_spawn_x (w_sx),
      .i_spawn_y (w_sy),
      .i_spawn_v (w_sv),
      .i_h1x     (w_h1x),
      .i_h1y     (w_h1y),
      .i_h2x     (w_h2x),
      .i_h2y     (w_h2y),
      .i_draw_x  (bus.DrawX),
      .i_draw_y  (bus.DrawY),
      .o_state   (w_st[g]),
      .o_value   (w_val[g]),
      .o_hit1    (w_hit1[g]),
      .o_hit2    (w_hit2[g]),
      .o_pix     (w_pix[g])
    );

    assign w_ov1[g]   = w_hit1[g] && (w_st[g] == S_ACTIVE);
    assign w_ov2[g]   = w_hit2[g] && (w_st[g] == S_ACTIVE);
    assign w_grant[g] = (w_g1 && w_c1 == 2'(g))
                     || (w_g2 && w_c2 == 2'(g));
    assign w_owner[g] = w_g2 && w_c2 == 2'(g);
  end

  always_comb begin
    w_c1     = 2'd0;
    w_c2     = 2'd0;
    w_c1_vld = 1'b0;
    w_c2_vld = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_ov1[i]) begin
        w_c1     = 2'(i);
        w_c1_vld = 1'b1;
      end
      if (w_ov2[i]) begin
        w_c2     = 2'(i);
        w_c2_vld = 1'b1;
      end
    end
    w_e1      = w_c1_vld && !bus.P1Dead && !r_busy1;
    w_e2      = w_c2_vld && !bus.P2Dead && !r_busy2;
    // Loser of a contested slot gets nothing this frame.
    w_contest = w_e1 && w_e2 && (w_c1 == w_c2);
    w_g1      = w_e1 && !(w_contest && r_rr);
    w_g2      = w_e2 && !(w_contest && !r_rr);
  end

  always_ff @(posedge FrameClk) begin
    if (w_clr) begin
      r_p1c   <= 2'd0;
      r_p2c   <= 2'd0;
      r_busy1 <= 1'b0;
      r_busy2 <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_p1c   <= w_g1 ? w_val[w_c1] : 2'd0;
      r_p2c   <= w_g2 ? w_val[w_c2] : 2'd0;
      r_busy1 <= w_g1;
      r_busy2 <= w_g2;
      if (w_contest) r_rr <= ~r_rr;
    end
  end

  assign bus.P1Collect = r_p1c;
  assign bus.P2Collect = r_p2c;

  always_comb begin
    bus.LootPixel = 1'b0;
    bus.LootValue = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_pix[i]) begin
        bus.LootPixel = 1'b1;
        bus.LootValue = w_val[i];
      end
    end
  end

endmodule

// File: tb/tb_loot_manager.sv
// tb_loot_manager: directed bench with offer scoreboard and raster checks.
// Default build (LOOT_RANDOM_EN undefined): deterministic spawn layout.
module tb_loot_manager;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  loot_manager_if bus ();

  loot_manager #(
    .NUM_SLOTS      (4),
    .RESPAWN_FRAMES (120)
  ) u_dut (
    .FrameClk (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  typedef struct {
    int         frame;
    logic [1:0] p1;
    logic [1:0] p2;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;
  int   fc   = 0;
  int   t1   = 0;

  always @(posedge clk) fc <= fc + 1;

  // Offer monitor: every nonzero offer must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.P1Collect != 2'd0 || bus.P2Collect != 2'd0) begin
      nvec++;
      if (sbq.size() == 0) begin
        nerr++;
        $display("FAIL offer_unexpected: frame=%0d p1=%0d p2=%0d",
                 fc, bus.P1Collect, bus.P2Collect);
      end else begin
        e = sbq.pop_front();
        if (e.frame != fc || e.p1 != bus.P1Collect
            || e.p2 != bus.P2Collect) begin
          nerr++;
          $display("FAIL offer: got frame=%0d p1=%0d p2=%0d want frame=%0d p1=%0d p2=%0d",
                   fc, bus.P1Collect, bus.P2Collect, e.frame, e.p1, e.p2);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_offer(input logic [1:0] p1, input logic [1:0] p2);
    exp_t e;
    e.frame = fc + 1;
    e.p1    = p1;
    e.p2    = p2;
    sbq.push_back(e);
  endtask

  task automatic chk_pix(input string nm, input logic [9:0] x,
                         input logic [9:0] y, input logic ep,
                         input logic [1:0] ev);
    bus.DrawX = x;
    bus.DrawY = y;
    #1;
    nvec++;
    if (bus.LootPixel !== ep || bus.LootValue !== ev) begin
      nerr++;
      $display("FAIL %s: pix=%b val=%0d want pix=%b val=%0d",
               nm, bus.LootPixel, bus.LootValue, ep, ev);
    end
  endtask

  task automatic place1(input logic [9:0] x, input logic [9:0] y,
                        input logic [4:0] off);
    bus.P1X        = x;
    bus.P1Y        = y;
    bus.P1HbOffset = off;
  endtask

  task automatic place2(input logic [9:0] x, input logic [9:0] y);
    bus.P2X        = x;
    bus.P2Y        = y;
    bus.P2HbOffset = 5'd0;
  endtask

  initial begin
    exp_t e;
    rst             = 1'b1;
    bus.RoundEnable = 1'b1;
    bus.P1Dead      = 1'b0;
    bus.P2Dead      = 1'b0;
    bus.P1Collected = 1'b0;
    bus.P2Collected = 1'b0;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd0;
    place1(10'd0, 10'd0, 5'd0);
    place2(10'd0, 10'd0);
    step(2);
    rst = 1'b0;

    nvec++;
    if (bus.P1Collect !== 2'd0 || bus.P2Collect !== 2'd0) begin
      nerr++;
      $display("FAIL reset_collect: p1=%0d p2=%0d want 0 0",
               bus.P1Collect, bus.P2Collect);
    end
    chk_pix("reset_pix", 10'd165, 10'd100, 1'b0, 2'd0);

    // First spawn lands on the 120th edge after release.
    step(60);
    chk_pix("empty_60", 10'd165, 10'd100, 1'b0, 2'd0);
    step(59);
    chk_pix("empty_119", 10'd165, 10'd100, 1'b0, 2'd0);
    step(1);
    chk_pix("spawn_s0", 10'd165, 10'd100, 1'b1, 2'd1);
    chk_pix("s0_corner", 10'd175, 10'd111, 1'b1, 2'd1);
    chk_pix("s0_right", 10'd176, 10'd100, 1'b0, 2'd0);
    chk_pix("s0_below", 10'd165, 10'd112, 1'b0, 2'd0);
    chk_pix("s0_left", 10'd159, 10'd100, 1'b0, 2'd0);
    chk_pix("spawn_s1", 10'd290, 10'd195, 1'b1, 2'd2);
    chk_pix("spawn_s2", 10'd420, 10'd290, 1'b1, 2'd3);
    chk_pix("spawn_s3", 10'd550, 10'd390, 1'b1, 2'd1);

    // Touching edges never overlap.
    place1(10'd176, 10'd80, 5'd0);
    step(2);
    place1(10'd160, 10'd96, 5'd0);
    step(2);

    // Single grab of slot 0.
    place1(10'd160, 10'd80, 5'd0);
    expect_offer(2'd1, 2'd0);
    step(1);
    bus.P1Collected = 1'b1;
    place1(10'd0, 10'd0, 5'd0);
    step(1);
    bus.P1Collected = 1'b0;
    chk_pix("s0_taken", 10'd165, 10'd100, 1'b0, 2'd0);
    step(119);
    chk_pix("s0_empty_119", 10'd165, 10'd100, 1'b0, 2'd0);
    step(1);
    chk_pix("s0_respawn", 10'd165, 10'd100, 1'b1, 2'd1);

    // Contention on slot 1, rr=0 favours P1.
    place1(10'd288, 10'd176, 5'd0);
    place2(10'd288, 10'd176);
    expect_offer(2'd2, 2'd0);
    step(1);
    bus.P1Collected = 1'b1;
    place1(10'd0, 10'd0, 5'd0);
    place2(10'd0, 10'd0);
    step(1);
    bus.P1Collected = 1'b0;
    t1 = fc;
    chk_pix("s1_taken", 10'd290, 10'd195, 1'b0, 2'd0);

    // Dead player gets nothing; then a full player is re-offered.
    bus.P1Dead = 1'b1;
    place1(10'd144, 10'd80, 5'd16);
    step(3);
    bus.P1Dead = 1'b0;
    e.frame = fc + 1; e.p1 = 2'd1; e.p2 = 2'd0; sbq.push_back(e);
    e.frame = fc + 3; sbq.push_back(e);
    e.frame = fc + 5; sbq.push_back(e);
    step(5);
    place1(10'd0, 10'd0, 5'd0);
    step(1);
    chk_pix("s0_kept", 10'd165, 10'd100, 1'b1, 2'd1);

    step(t1 + 119 - fc);
    chk_pix("s1_empty_119", 10'd290, 10'd195, 1'b0, 2'd0);
    step(1);
    chk_pix("s1_respawn", 10'd290, 10'd195, 1'b1, 2'd2);

    // Second contention, rr=1 favours P2.
    place1(10'd288, 10'd176, 5'd0);
    place2(10'd288, 10'd176);
    expect_offer(2'd0, 2'd2);
    step(1);
    bus.P2Collected = 1'b1;
    place1(10'd0, 10'd0, 5'd0);
    place2(10'd0, 10'd0);
    step(1);
    bus.P2Collected = 1'b0;
    chk_pix("s1_taken_p2", 10'd290, 10'd195, 1'b0, 2'd0);

    // Round ends during the offer window.
    place1(10'd160, 10'd80, 5'd0);
    expect_offer(2'd1, 2'd0);
    step(1);
    bus.RoundEnable = 1'b0;
    bus.P1Collected = 1'b1;
    place1(10'd0, 10'd0, 5'd0);
    step(1);
    bus.RoundEnable = 1'b1;
    bus.P1Collected = 1'b0;
    chk_pix("round_s0", 10'd165, 10'd100, 1'b0, 2'd0);
    chk_pix("round_s2", 10'd420, 10'd290, 1'b0, 2'd0);
    step(119);
    chk_pix("round_empty_119", 10'd165, 10'd100, 1'b0, 2'd0);
    step(1);
    chk_pix("round_respawn", 10'd165, 10'd100, 1'b1, 2'd1);
    chk_pix("round_respawn_s3", 10'd550, 10'd390, 1'b1, 2'd1);

    step(3);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      nvec++;
      nerr++;
      $display("FAIL offer_missing: want frame=%0d p1=%0d p2=%0d got none",
               e.frame, e.p1, e.p2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
